fir_coeff_update_ctrl: RTL and testbench

Sequencer for the reconfigurable transposed FIR filter (`ReConf_FirFilter` coefficient SRAM and sample path).
- Accepts a coefficient reload request plus a valid/ready stream of 16-bit signed taps.
- Writes the taps into the filter's four 10-entry coefficient banks and zero-fills the unused slots.
- Generates the 600 kHz sample-enable strobe from the 12 MHz clock, masked for the whole reload so the filter never computes with a partially updated tap set.
- Sits between the host/config interface and the FIR filter's `iEnSample_600k`, `iCoeffiUpdateFlag`, `iCsnRam`, `iWrnRam`, `iAddrRam`, `iWrDtRam` and `iNumOfCoeff` inputs.

---
 rtl/fir_coeff_update_ctrl_if.sv | 33 +++
 rtl/fir_coeff_update_ctrl.sv | 132 +++++++++++++
 tb/tb_fir_coeff_update_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_update_ctrl_if.sv
// Host/config and coefficient-RAM signal bundle for the FIR coefficient update sequencer.
// The master side is the host (it drives the i* signals), and the slave side is the sequencer.
interface fir_coeff_update_ctrl_if #(
  parameter int COEFF_W = 16
);
  logic               iUpdateReq;
  logic [5:0]         iNumOfCoeffCfg;
  logic               iCoeffValid;
  logic [COEFF_W-1:0] iCoeffData;
  logic               oCoeffReady;
  logic               oEnSample_600k;
  logic               oCoeffiUpdateFlag;
  logic               oCsnRam;
  logic               oWrnRam;
  logic [3:0]         oAddrRam;
  logic [COEFF_W-1:0] oWrDtRam;
  logic [5:0]         oNumOfCoeff;
  logic               oBusy;
  logic               oDone;
  logic               oErr;

  modport master (
    output iUpdateReq, iNumOfCoeffCfg, iCoeffValid, iCoeffData,
    input  oCoeffReady, oEnSample_600k, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
           oAddrRam, oWrDtRam, oNumOfCoeff, oBusy, oDone, oErr
  );

  modport slave (
    input  iUpdateReq, iNumOfCoeffCfg, iCoeffValid, iCoeffData,
    output oCoeffReady, oEnSample_600k, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
           oAddrRam, oWrDtRam, oNumOfCoeff, oBusy, oDone, oErr
  );
endinterface

// File: rtl/fir_coeff_update_ctrl.sv
// Reloads the FIR coefficient banks from a tap stream, zero-fills unused slots,
// and produces the 600 kHz sample strobe, which stays masked while a reload is in progress.
module fir_coeff_update_ctrl #(
  parameter int DIV        = 20,
  parameter int COEFF_W    = 16,
  parameter int BANK_DEPTH = 10,
  parameter int NUM_SLOT   = 40
) (
  input logic                 iClk_12M,
  input logic                 iRst,
  fir_coeff_update_ctrl_if.slave bus
);
  localparam int               CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [5:0]       MAX_N     = 6'(NUM_SLOT);
  localparam logic [5:0]       LAST_SLOT = 6'(NUM_SLOT - 1);
  localparam logic [3:0]       LAST_ADDR = 4'(BANK_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [5:0]         n_reg;
  logic [5:0]         slot;
  logic [3:0]         addr_cnt;
  logic [CNT_W-1:0]   sample_cnt;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               csn_q;
  logic               wrn_q;
  logic [3:0]         addr_q;
  logic [5:0]         num_q;
  logic [COEFF_W-1:0] data_q;
  logic               req_ok;
  logic               req_bad;
  logic               handshake;
  logic               last_tap;
  logic               ready;
  logic               wr_en;
  logic [COEFF_W-1:0] wr_data;

  assign req_ok    = bus.iUpdateReq && (bus.iNumOfCoeffCfg != 6'd0) &&
                     (bus.iNumOfCoeffCfg <= MAX_N);
  assign req_bad   = bus.iUpdateReq && !req_ok;
  assign handshake = bus.iCoeffValid && ready;
  assign last_tap  = (slot == n_reg - 6'd1);

  always_ff @(posedge iClk_12M) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_ok) state_next = LOAD;
      LOAD: if (handshake && last_tap) state_next = (n_reg == MAX_N) ? DONE : FILL;
      FILL: if (slot == LAST_SLOT) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state)
      LOAD: begin
        ready   = 1'b1;
        wr_en   = bus.iCoeffValid;
        wr_data = bus.iCoeffData;
      end
      FILL: wr_en = 1'b1;
      default: ;
    endcase
  end

  // All RAM-side outputs are registered, so every write and the DONE pulse appear one cycle after they are decided.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      n_reg      <= '0;
      slot       <= '0;
      addr_cnt   <= 4'd1;
      sample_cnt <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      csn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      addr_q     <= '0;
      num_q      <= '0;
      data_q     <= '0;
    end else begin
      csn_q  <= ~wr_en;
      wrn_q  <= ~wr_en;
      busy_q <= (state_next != IDLE);
      done_q <= (state == DONE);
      err_q  <= (state == IDLE) && req_bad;
      if (wr_en) begin
        addr_q   <= addr_cnt;
        num_q    <= slot;
        data_q   <= wr_data;
        slot     <= slot + 6'd1;
        addr_cnt <= (addr_cnt == LAST_ADDR) ? 4'd1 : addr_cnt + 4'd1;
      end
      if (state == IDLE && req_ok) begin
        n_reg    <= bus.iNumOfCoeffCfg;
        slot     <= '0;
        addr_cnt <= 4'd1;
        num_q    <= '0;
      end
      if (state == DONE) num_q <= n_reg;
      // Restart on the visible DONE cycle so the first strobe lands exactly DIV cycles later.
      if (done_q || sample_cnt == CNT_LAST) sample_cnt <= '0;
      else                                  sample_cnt <= sample_cnt + 1'b1;
    end
  end

  assign bus.oCoeffReady       = ready;
  assign bus.oEnSample_600k    = (sample_cnt == CNT_LAST) && !busy_q && !done_q;
  assign bus.oCoeffiUpdateFlag = busy_q;
  assign bus.oBusy             = busy_q;
  assign bus.oDone             = done_q;
  assign bus.oErr              = err_q;
  assign bus.oCsnRam           = csn_q;
  assign bus.oWrnRam           = wrn_q;
  assign bus.oAddrRam          = addr_q;
  assign bus.oWrDtRam          = data_q;
  assign bus.oNumOfCoeff       = num_q;
endmodule

// File: tb/tb_fir_coeff_update_ctrl.sv
// Scoreboard bench for fir_coeff_update_ctrl: expected RAM writes are queued as taps are
// accepted, then matched against what the DUT puts on the RAM port.
module tb_fir_coeff_update_ctrl;
  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [5:0]  idx;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   last39Cyc;
  int   errPulses;
  int   strobeBusy;
  wr_t  expQ[$];
  logic [15:0] tapTable [4] = '{16'h0003, 16'h0000, 16'hFFFA, 16'h8000};

  fir_coeff_update_ctrl_if #(.COEFF_W(16)) bus ();

  fir_coeff_update_ctrl dut (
    .iClk_12M (clk),
    .iRst     (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushWrite(input int when, input int idx, input logic [15:0] d);
    wr_t e;
    e.cyc  = when;
    e.addr = 4'((idx % 10) + 1);
    e.idx  = 6'(idx);
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_csn"}, bus.oCsnRam, 1);
    checkOutput({tag, "_wrn"}, bus.oWrnRam, 1);
    checkOutput({tag, "_busy"}, bus.oBusy, 0);
    checkOutput({tag, "_flag"}, bus.oCoeffiUpdateFlag, 0);
    checkOutput({tag, "_ready"}, bus.oCoeffReady, 0);
    checkOutput({tag, "_strobe"}, bus.oEnSample_600k, 0);
    checkOutput({tag, "_done"}, bus.oDone, 0);
    checkOutput({tag, "_err"}, bus.oErr, 0);
    checkOutput({tag, "_num"}, bus.oNumOfCoeff, 0);
    checkOutput({tag, "_addr"}, bus.oAddrRam, 0);
    checkOutput({tag, "_data"}, bus.oWrDtRam, 0);
  endtask

  // Compares every RAM write against the queue and tracks strobes that occur during a reload, plus oErr pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.oEnSample_600k && (bus.oBusy || bus.oCoeffiUpdateFlag)) strobeBusy++;
      if (bus.oErr) errPulses++;
      if (!bus.oCsnRam || !bus.oWrnRam) begin
        if (expQ.size() == 0) begin
          checkOutput("write_expected", expQ.size(), 1);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("wr_cycle", cyc, e.cyc);
          checkOutput("wr_csn", bus.oCsnRam, 0);
          checkOutput("wr_wrn", bus.oWrnRam, 0);
          checkOutput("wr_addr", bus.oAddrRam, e.addr);
          checkOutput("wr_index", bus.oNumOfCoeff, e.idx);
          checkOutput("wr_data", bus.oWrDtRam, e.data);
          if (e.idx == 6'd39) last39Cyc = cyc;
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input bit toggle, input bit extraReq, input int abortAfter);
    int accepted;
    int limit;
    int budget;
    int lastAcceptCyc;
    int doneCyc;
    int k;
    bit phase;
    logic [15:0] d;
    expQ.delete();
    limit = (abortAfter > 0) ? abortAfter : n;
    bus.iNumOfCoeffCfg = 6'(n);
    bus.iUpdateReq = 1'b1;
    @(posedge clk); #1;
    bus.iUpdateReq = 1'b0;
    checkOutput("req_busy", bus.oBusy, 1);
    checkOutput("req_flag", bus.oCoeffiUpdateFlag, 1);
    checkOutput("req_ready", bus.oCoeffReady, 1);
    accepted = 0;
    budget = 200;
    phase = 1'b1;
    lastAcceptCyc = 0;
    d = toggle ? 16'($urandom) : tapTable[0];
    while (accepted < limit && budget > 0) begin
      bus.iCoeffValid = toggle ? phase : 1'b1;
      bus.iCoeffData = d;
      bus.iUpdateReq = extraReq && (accepted == 3);
      if (extraReq) bus.iNumOfCoeffCfg = 6'd5;
      if (bus.iCoeffValid && bus.oCoeffReady) begin
        pushWrite(cyc + 1, accepted, d);
        lastAcceptCyc = cyc;
        accepted++;
        d = toggle ? 16'($urandom) : tapTable[accepted % 4];
      end
      phase = ~phase;
      @(posedge clk); #1;
      budget--;
    end
    bus.iCoeffValid = 1'b0;
    bus.iUpdateReq = 1'b0;
    if (accepted < limit) begin
      checkOutput("accept_timeout", accepted, limit);
      return;
    end
    if (abortAfter > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      checkResetValues("abort");
      rst = 1'b0;
      expQ.delete();
      return;
    end
    checkOutput("ready_drop", bus.oCoeffReady, 0);
    for (int s = n; s < 40; s++) pushWrite(lastAcceptCyc + 2 + s - n, s, 16'h0000);
    budget = 100;
    while (!bus.oDone && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checkOutput("done_seen", bus.oDone, 1);
    doneCyc = (n == 40) ? lastAcceptCyc + 2 : lastAcceptCyc + 2 + 39 - n + 1;
    checkOutput("done_cycle", cyc, doneCyc);
    checkOutput("done_after_slot39", cyc - last39Cyc, 1);
    checkOutput("done_busy", bus.oBusy, 0);
    checkOutput("done_flag", bus.oCoeffiUpdateFlag, 0);
    checkOutput("done_num", bus.oNumOfCoeff, n);
    checkOutput("done_queue_empty", expQ.size(), 0);
    @(posedge clk); #1;
    checkOutput("post_done_pulse", bus.oDone, 0);
    k = 1;
    while (!bus.oEnSample_600k && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("strobe_after_done", k, 20);
  endtask

  task automatic badRequest(input logic [5:0] cfg, input int prevN);
    bus.iNumOfCoeffCfg = cfg;
    bus.iUpdateReq = 1'b1;
    @(posedge clk); #1;
    bus.iUpdateReq = 1'b0;
    checkOutput("err_pulse", bus.oErr, 1);
    checkOutput("err_busy", bus.oBusy, 0);
    @(posedge clk); #1;
    checkOutput("err_single", bus.oErr, 0);
    checkOutput("err_busy_after", bus.oBusy, 0);
    checkOutput("err_keep_n", bus.oNumOfCoeff, prevN);
  endtask

  initial begin
    int firstStrobe;
    int strobeCnt;
    int strobeBad;
    int ramActive;
    int errBefore;
    checks = 0;
    errors = 0;
    last39Cyc = 0;
    errPulses = 0;
    strobeBusy = 0;
    rst = 1'b1;
    bus.iUpdateReq = 1'b0;
    bus.iNumOfCoeffCfg = '0;
    bus.iCoeffValid = 1'b0;
    bus.iCoeffData = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    firstStrobe = 0;
    strobeCnt = 0;
    strobeBad = 0;
    ramActive = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (bus.oEnSample_600k) begin
        strobeCnt++;
        if (firstStrobe == 0) firstStrobe = c;
      end
      if (bus.oEnSample_600k != (c % 20 == 0)) strobeBad++;
      if (!bus.oCsnRam || !bus.oWrnRam) ramActive++;
    end
    checkOutput("idle_first_strobe", firstStrobe, 20);
    checkOutput("idle_strobe_count", strobeCnt, 5);
    checkOutput("idle_strobe_period", strobeBad, 0);
    checkOutput("idle_ram_quiet", ramActive, 0);

    applyStimulus(33, 1'b0, 1'b0, 0);

    errBefore = errPulses;
    applyStimulus(10, 1'b1, 1'b1, 0);
    checkOutput("busy_req_no_err", errPulses - errBefore, 0);

    badRequest(6'd0, 10);
    badRequest(6'd41, 10);

    applyStimulus(20, 1'b0, 1'b0, 5);
    applyStimulus(40, 1'b0, 1'b0, 0);

    checkOutput("no_strobe_while_busy", strobeBusy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
